fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_push_arbiter_pkg.sv | 11 +
 rtl/rr_pick.sv | 39 +++
 rtl/fifo_push_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// rtl/fifo_push_arbiter_pkg.sv - shared pipeline constants for the FIFO and stage modules
//
// Purpose: the default payload width (instr, addr, PC+4) and the width of
//          delivered-beat counters, shared by every pipeline stage module.
// Ports:   none (package).
package fifo_push_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 96;
  localparam int PUSH_COUNT_W  = 32;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose: picks the first set bit of valid, searching upward from ptr+1 and
//          wrapping modulo NREQ, so the last winner gets lowest priority.
// Ports:
//   valid  in  [NREQ-1:0]  request vector
//   ptr    in  [IDW-1:0]   index of the previous winner
//   grant  out [NREQ-1:0]  one-hot winner (zero when nothing is valid)
//   idx    out [IDW-1:0]   binary index of the winner
//   any    out             at least one request is valid
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Offsets 1..NREQ: the previous winner itself is examined last.
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin arbiter sharing one FIFO push port
//
// Purpose: NREQ requesters compete for a single FIFO push port. One output
//          register holds the beat being pushed; a new beat is accepted when
//          the register is empty or is being delivered the same cycle.
// Ports:
//   CLK                 in              rising-edge clock
//   RESET               in              asynchronous active-high reset
//   req_valid           in  [NREQ-1:0]  requester i offers a beat
//   req_data            in  [NREQ*WIDTH-1:0] slice i is requester i's payload
//   req_ready           out [NREQ-1:0]  requester i's beat is taken this cycle
//   fifo_pushing        out             push strobe to the shared FIFO
//   fifo_in_data        out [WIDTH-1:0] payload to the shared FIFO
//   fifo_push_must_wait in              FIFO refused the current push
//   grant_id            out [IDW-1:0]   source index of the held beat
//   push_count          out [31:0]      total beats delivered (wraps)
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_pushing,
  output logic [WIDTH-1:0]        fifo_in_data,
  input  logic                    fifo_push_must_wait,
  output logic [IDW-1:0]          grant_id,
  output logic [PUSH_COUNT_W-1:0] push_count
);

  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [IDW-1:0]          out_id;
  logic [IDW-1:0]          rr_ptr;
  logic [PUSH_COUNT_W-1:0] push_count_q;

  logic [NREQ-1:0]  pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_data;
  logic             deliver;
  logic             accept;
  logic             take;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // One-hot mux of the winning payload slice.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        pick_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign deliver = out_valid & ~fifo_push_must_wait;
  // Bubble-free: the register can refill in the cycle it drains.
  assign accept  = ~out_valid | ~fifo_push_must_wait;
  // RESET gates the handshake combinationally so nothing is taken while held.
  assign take    = accept & pick_any & ~RESET;

  assign req_ready = take ? pick_grant : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_id       <= '0;
      rr_ptr       <= IDW'(NREQ - 1);
      push_count_q <= '0;
    end else begin
      if (deliver) begin
        push_count_q <= push_count_q + PUSH_COUNT_W'(1);
      end
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= pick_data;
        out_id    <= pick_idx;
        rr_ptr    <= pick_idx;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign fifo_pushing = out_valid;
  assign fifo_in_data = out_data;
  assign grant_id     = out_id;
  assign push_count   = push_count_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - directed self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 96;

  logic                  CLK;
  logic                  RESET;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_pushing;
  logic [WIDTH-1:0]      fifo_in_data;
  logic                  fifo_push_must_wait;
  logic [1:0]            grant_id;
  logic [31:0]           push_count;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_push_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .fifo_pushing        (fifo_pushing),
    .fifo_in_data        (fifo_in_data),
    .fifo_push_must_wait (fifo_push_must_wait),
    .grant_id            (grant_id),
    .push_count          (push_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [WIDTH-1:0] beat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'hADD0_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET               = 1'b1;
    req_valid           = '0;
    fifo_push_must_wait = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET               = 1'b1;
    req_valid           = 4'b1111;
    fifo_push_must_wait = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = beat(i);

    // Reset state, before any clock edge.
    #1;
    check("rst_pushing", fifo_pushing, 0);
    check("rst_data",    fifo_in_data, 0);
    check("rst_gid",     grant_id, 0);
    check("rst_count",   push_count, 0);
    check("rst_ready",   req_ready, 0);
    check("rst_ptr",     dut.rr_ptr, 3);
    tick();
    tick();
    check("rst_ready_clk", req_ready, 0);
    RESET = 1'b0;

    // All four valid, no stall: 0,1,2,3,0 back to back.
    #1;
    check("all_ready0", req_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("all_gid%0d", k),  grant_id, (k % 4));
      check($sformatf("all_push%0d", k), fifo_pushing, 1);
      check($sformatf("all_data%0d", k), fifo_in_data, beat(k % 4));
      check($sformatf("all_cnt%0d", k),  push_count, k);
      check($sformatf("all_rdy%0d", k),  req_ready, 4'b0001 << ((k + 1) % 4));
    end
    req_valid = '0;
    #1;
    check("all_idle_ready", req_ready, 0);
    tick();
    check("all_cnt_final", push_count, 5);
    check("all_drained",   fifo_pushing, 0);

    // 0101 held: alternate 0,2.
    do_reset();
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("alt_rdy%0d", k), req_ready, (k % 2) ? 4'b0100 : 4'b0001);
      check($sformatf("alt_odd%0d", k), req_ready & 4'b1010, 0);
      tick();
      check($sformatf("alt_gid%0d", k), grant_id, (k % 2) ? 2 : 0);
    end

    // Stall on a beat from id 1 for three cycles.
    do_reset();
    req_valid = 4'b0010;
    #1;
    check("stl_rdy1", req_ready, 4'b0010);
    tick();
    check("stl_gid1", grant_id, 1);
    req_valid           = 4'b1111;
    fifo_push_must_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stl_rdy%0d", k),  req_ready, 0);
      check($sformatf("stl_gid%0d", k),  grant_id, 1);
      check($sformatf("stl_data%0d", k), fifo_in_data, beat(1));
      check($sformatf("stl_ptr%0d", k),  dut.rr_ptr, 1);
      check($sformatf("stl_push%0d", k), fifo_pushing, 1);
      check($sformatf("stl_cnt%0d", k),  push_count, 0);
      tick();
    end
    fifo_push_must_wait = 1'b0;
    #1;
    check("stl_rel_rdy", req_ready, 4'b0100);
    tick();
    check("stl_rel_gid", grant_id, 2);
    check("stl_rel_cnt", push_count, 1);

    // Only requester 3, pointer already at 3: wrap re-grants every cycle.
    do_reset();
    check("wrp_ptr", dut.rr_ptr, 3);
    req_valid = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("wrp_rdy%0d", k), req_ready, 4'b1000);
      tick();
      check($sformatf("wrp_gid%0d", k),  grant_id, 3);
      check($sformatf("wrp_push%0d", k), fifo_pushing, 1);
      check($sformatf("wrp_cnt%0d", k),  push_count, k);
    end

    // Reset mid-clock with a beat held: it is discarded.
    #3;
    RESET = 1'b1;
    #1;
    check("mid_push",  fifo_pushing, 0);
    check("mid_cnt",   push_count, 0);
    check("mid_ready", req_ready, 0);
    check("mid_gid",   grant_id, 0);
    tick();
    RESET     = 1'b0;
    req_valid = '0;
    tick();
    check("mid_no_push", fifo_pushing, 0);
    check("mid_no_cnt",  push_count, 0);
    req_valid = 4'b1111;
    #1;
    check("mid_first_rdy", req_ready, 4'b0001);
    tick();
    check("mid_first_gid", grant_id, 0);
    req_valid = '0;
    tick();
    check("mid_cnt1", push_count, 1);

    // push_count wrap.
    do_reset();
    force dut.push_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.push_count_q;
    #1;
    check("wrap_pre", push_count, 32'hFFFF_FFFF);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    check("wrap_held", push_count, 32'hFFFF_FFFF);
    tick();
    check("wrap_cnt",  push_count, 0);
    check("wrap_push", fifo_pushing, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
